pdm_capture_ctrl: RTL and testbench
===================================

PDM_CAPTURE_CTRL -- requirements
Module: pdm_capture_ctrl

Interface
REQ-001 Parameter DIV_W, default 8: width of the PDM half-period divider setting.
REQ-002 Parameter WIN_LOG2, default 6: log2 of PDM bits per output sample (64).
REQ-003 Parameter FIFO_DEPTH, default 4: output sample buffer depth, power of two.
REQ-004 Parameter WARMUP_WIN, default 4: sample windows discarded after each start.
REQ-005 Port clock, input, 1: system clock, 100 MHz.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port enable, input, 1: level; 1 = capture runs, 0 = stop.
REQ-008 Port half_period, input, DIV_W: clock_pdm half-period minus one, in clock cycles.
REQ-009 Port chan_sel, input, 1: 0 = left, 1 = right microphone channel.
REQ-010 Port mic_in_pdm, input, 1: microphone PDM data.
REQ-011 Port clock_pdm, output, 1: generated microphone clock.
REQ-012 Port sel_LR, output, 1: microphone L/R select, equals the latched chan_sel.
REQ-013 Port sample_data, output, WIN_LOG2+1: ones-count of one window (0..64), FIFO head.
REQ-014 Port sample_valid, output, 1: FIFO not empty.
REQ-015 Port sample_ready, input, 1: consumer accepts; pop when valid and ready.
REQ-016 Port overflow, output, 1: sticky; a completed sample was dropped.
REQ-017 Port overflow_clr, input, 1: single-cycle clear of overflow.
REQ-018 Port busy, output, 1: state is not IDLE.

Function
REQ-019 States IDLE, WARMUP, RUN; IDLE->WARMUP when enable=1; WARMUP->RUN after WARMUP_WIN completed windows; any state->IDLE on the cycle after enable=0.
REQ-020 On IDLE->WARMUP: latch half_period and chan_sel; clear divider, accumulator and window counters; changes to either input take effect only on the next start.
REQ-021 Divider counts 0..half_period; on a terminal count it returns to 0 and clock_pdm toggles; clock_pdm period = 2*(half_period+1) cycles; half_period=0 toggles every cycle.
REQ-022 In IDLE, clock_pdm is held 0 and the divider is held at 0.
REQ-023 Sampling cycle: the terminal-count cycle on which clock_pdm goes 1->0 when latched chan_sel=0, or 0->1 when it is 1; mic_in_pdm is registered there.
REQ-024 On each sampling cycle, accumulator += bit and bit counter += 1; after 2^WIN_LOG2 bits the window completes, the count is produced, and both reset to 0 with no lost bit.
REQ-025 In WARMUP, completed windows are discarded; in RUN, each is pushed to the FIFO on the clock edge after its last sampling cycle.
REQ-026 sample_valid asserts exactly 2 cycles after the sampling cycle of the window's last bit when the FIFO was empty.
REQ-027 Push when full without a simultaneous pop: the new sample is dropped, FIFO is unchanged, and overflow is set.
REQ-028 Push and pop in the same cycle, including when full: both take effect and the count is unchanged.
REQ-029 overflow_clr and a new overflow event in the same cycle: overflow stays 1.
REQ-030 enable=0 mid-window: the partial window is discarded and the FIFO contents remain poppable.
REQ-031 FIFO occupancy is independent of state; sample_data is don't-care while sample_valid=0.

Reset
REQ-032 Asserting reset asynchronously forces: state IDLE, clock_pdm=0, sel_LR=0, sample_valid=0, sample_data=0, overflow=0, busy=0, FIFO empty, all counters 0.
REQ-033 Deassertion is synchronised internally; the first possible state change occurs on the second clock edge after release.

Structure
REQ-034 Package pdm_ctrl_pkg holds the state enumeration and the default values of DIV_W, WIN_LOG2, FIFO_DEPTH and WARMUP_WIN.
REQ-035 A single sub-module, pdm_sample_fifo, implements the show-ahead synchronous FIFO with full/empty flags.

Verification
REQ-036 half_period=15, chan_sel=0, mic_in_pdm=1, ready=1, enable rises -> clock_pdm period 32 cycles, sel_LR=0; first sample_valid 5*64*32=10240 cycles (+2) after start; data=64.
REQ-037 mic_in_pdm alternating 1/0 per sampling cycle, chan_sel=1 -> sel_LR=1, sampling on the clock_pdm rising toggle, every sample=32.
REQ-038 sample_ready=0 for 5 RUN windows with distinct counts -> FIFO holds the first four, 5th dropped, overflow=1; overflow_clr -> 0; draining returns the four in order.
REQ-039 enable=0 at bit 30 of a RUN window -> clock_pdm=0 the next cycle, no partial sample pushed, busy=0; re-enable -> WARMUP repeats (4 windows discarded).
REQ-040 reset low mid-RUN with FIFO at 2 entries -> all outputs 0 immediately with no clock edge; after release, a new start behaves as in REQ-036.
REQ-041 half_period=0 -> clock_pdm toggles every cycle; a full-then-pop-and-push same cycle keeps occupancy at 4 with no overflow.

Source files
------------

// File: rtl/pdm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pdm_ctrl_pkg                                              |
// | Purpose  : Shared state encoding and parameter defaults for the PDM  |
// |            microphone capture controller.                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pdm_ctrl_pkg;

  localparam int DIV_W_DEF      = 8;  // divider setting width
  localparam int WIN_LOG2_DEF   = 6;  // 64 PDM bits per output sample
  localparam int FIFO_DEPTH_DEF = 4;  // output buffer entries (power of two, >= 2)
  localparam int WARMUP_WIN_DEF = 4;  // windows discarded after each start (>= 1)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } pdm_state_e;

endpackage : pdm_ctrl_pkg
`default_nettype wire

// File: rtl/pdm_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pdm_sample_fifo                                           |
// | Purpose  : Show-ahead synchronous FIFO for completed PDM samples.    |
// |            Head entry is always visible on data_o; a push while full |
// |            is accepted only if a pop happens in the same cycle.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pdm_sample_fifo
  import pdm_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = WIN_LOG2_DEF + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop   = pop_i && !empty_o;
  // When full, the slot being written is the one being popped this cycle.
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update for accepted pushes and pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule : pdm_sample_fifo
`default_nettype wire

// File: rtl/pdm_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pdm_capture_ctrl                                          |
// | Purpose  : Generates the PDM microphone clock, counts ones over a    |
// |            2^WIN_LOG2-bit window and buffers the counts in a FIFO,   |
// |            discarding WARMUP_WIN windows after every start.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pdm_capture_ctrl
  import pdm_ctrl_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int WIN_LOG2   = WIN_LOG2_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int WARMUP_WIN = WARMUP_WIN_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  half_period,
  input  logic              chan_sel,
  input  logic              mic_in_pdm,
  output logic              clock_pdm,
  output logic              sel_LR,
  output logic [WIN_LOG2:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic              busy
);

  localparam int ACC_W = WIN_LOG2 + 1;
  localparam int WC_W  = (WARMUP_WIN > 1) ? $clog2(WARMUP_WIN) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WARMUP_WIN - 1);

  logic              rst_sync_q;
  pdm_state_e        state_q, state_d;
  logic [DIV_W-1:0]  hp_q, hp_d;
  logic              sel_q, sel_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              pclk_q, pclk_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WIN_LOG2-1:0] bitcnt_q, bitcnt_d;
  logic [WC_W-1:0]   wincnt_q, wincnt_d;
  logic              done_q, done_d;
  logic [ACC_W-1:0]  win_data_q, win_data_d;
  logic              overflow_q, overflow_d;

  logic              w_tc;
  logic              w_samp;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;

  // Reset assertion propagates at once; release is retimed by one flop so
  // the first state change lands on the second edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  // Terminal count of the divider, and the sampling edge for the latched
  // channel: falling toggle for left, rising toggle for right.
  assign w_tc   = (div_q == hp_q);
  assign w_samp = (state_q != ST_IDLE) && w_tc && (pclk_q != sel_q);

  // Next-state logic: start/stop control, divider, window accumulator.
  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    sel_d      = sel_q;
    div_d      = div_q;
    pclk_d     = pclk_q;
    acc_d      = acc_q;
    bitcnt_d   = bitcnt_q;
    wincnt_d   = wincnt_q;
    done_d     = 1'b0;
    win_data_d = win_data_q;
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        pclk_d = 1'b0;
        if (enable) begin
          state_d  = ST_WARMUP;
          hp_d     = half_period;
          sel_d    = chan_sel;
          acc_d    = '0;
          bitcnt_d = '0;
          wincnt_d = '0;
        end
      end
      default: begin
        if (!enable) begin
          // Any partial window is abandoned; FIFO contents are untouched.
          state_d  = ST_IDLE;
          div_d    = '0;
          pclk_d   = 1'b0;
          acc_d    = '0;
          bitcnt_d = '0;
          wincnt_d = '0;
        end else begin
          if (w_tc) begin
            div_d  = '0;
            pclk_d = ~pclk_q;
          end else begin
            div_d  = div_q + DIV_W'(1);
          end
          if (w_samp) begin
            bitcnt_d = bitcnt_q + WIN_LOG2'(1);
            if (&bitcnt_q) begin
              // Last bit of the window folds straight into the result so the
              // next window starts from zero without losing a bit.
              win_data_d = acc_q + ACC_W'(mic_in_pdm);
              acc_d      = '0;
              if (state_q == ST_RUN) begin
                done_d = 1'b1;
              end else if (wincnt_q == WC_LAST) begin
                state_d  = ST_RUN;
                wincnt_d = '0;
              end else begin
                wincnt_d = wincnt_q + WC_W'(1);
              end
            end else begin
              acc_d = acc_q + ACC_W'(mic_in_pdm);
            end
          end
        end
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clock or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= ST_IDLE;
      hp_q       <= '0;
      sel_q      <= 1'b0;
      div_q      <= '0;
      pclk_q     <= 1'b0;
      acc_q      <= '0;
      bitcnt_q   <= '0;
      wincnt_q   <= '0;
      done_q     <= 1'b0;
      win_data_q <= '0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
      pclk_q     <= pclk_d;
      acc_q      <= acc_d;
      bitcnt_q   <= bitcnt_d;
      wincnt_q   <= wincnt_d;
      done_q     <= done_d;
      win_data_q <= win_data_d;
    end
  end

  // A completed sample is lost only when the buffer is full and not draining.
  assign w_pop      = sample_valid && sample_ready;
  assign w_drop     = done_q && w_full && !w_pop;
  assign overflow_d = w_drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

  // Sticky overflow flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clock or negedge rst_sync_q) begin
    if (!rst_sync_q) overflow_q <= 1'b0;
    else             overflow_q <= overflow_d;
  end

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ACC_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_sync_q),
    .push_i  (done_q),
    .data_i  (win_data_q),
    .pop_i   (sample_ready),
    .data_o  (sample_data),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign sample_valid = !w_empty;
  assign clock_pdm    = pclk_q;
  assign sel_LR       = sel_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != ST_IDLE);

endmodule : pdm_capture_ctrl
`default_nettype wire

// File: tb/tb_pdm_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pdm_capture_ctrl                                       |
// | Purpose  : Self-checking bench for pdm_capture_ctrl against a        |
// |            cycle-level behavioural model of the capture rules.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pdm_capture_ctrl;

  localparam int WIN    = 64;
  localparam int WARMUP = 4;
  localparam int FDEPTH = 4;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] half_period;
  logic       chan_sel;
  logic       mic_in_pdm;
  logic       clock_pdm;
  logic       sel_LR;
  logic [6:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       overflow;
  logic       overflow_clr;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus modes applied by the background driver
  int mic_mode = 0;   // 0 const 1, 1 alternate per sample, 2 random, 3 per-window density
  int rdy_mode = 0;   // 0 fixed value rdy_fix, 1 random
  bit rdy_fix  = 1'b0;
  bit chk_on   = 1'b0;

  // behavioural model state
  bit m_sync     = 1'b0;
  bit m_active   = 1'b0;
  bit m_sel      = 1'b0;
  bit m_ovf      = 1'b0;
  bit m_push     = 1'b0;
  int m_pdata    = 0;
  int m_n        = 0;
  int m_H        = 1;
  int m_bits     = 0;
  int m_sum      = 0;
  int m_run_wins = 0;
  int m_q[$];

  pdm_capture_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .half_period  (half_period),
    .chan_sel     (chan_sel),
    .mic_in_pdm   (mic_in_pdm),
    .clock_pdm    (clock_pdm),
    .sel_LR       (sel_LR),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: the window/FIFO rules evaluated arithmetically once per edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_sync = 1'b0; m_active = 1'b0; m_sel = 1'b0; m_ovf = 1'b0;
      m_push = 1'b0; m_n = 0; m_bits = 0; m_sum = 0;
      m_q.delete();
    end else if (!m_sync) begin
      m_sync = 1'b1;
    end else begin
      bit pop;
      bit drop;
      pop  = (m_q.size() > 0) && sample_ready;
      drop = m_push && (m_q.size() == FDEPTH) && !pop;
      if (pop) void'(m_q.pop_front());
      if (m_push && !drop) m_q.push_back(m_pdata);
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_push = 1'b0;
      if (m_active) begin
        if (!enable) begin
          m_active = 1'b0;
        end else begin
          m_n++;
          if ((m_n % (2 * m_H)) == (m_sel ? m_H : 0)) begin
            m_bits++;
            m_sum += int'(mic_in_pdm);
            if (m_bits % WIN == 0) begin
              if (m_bits / WIN > WARMUP) begin
                m_push  = 1'b1;
                m_pdata = m_sum;
                m_run_wins++;
              end
              m_sum = 0;
            end
          end
        end
      end else if (enable) begin
        m_active = 1'b1;
        m_n      = 0;
        m_H      = int'(half_period) + 1;
        m_sel    = chan_sel;
        m_bits   = 0;
        m_sum    = 0;
      end
    end
  end

  // Every cycle, compare all outputs with the model just after the edge.
  always @(posedge clock) begin
    #1;
    if (chk_on) begin
      check_eq("busy", 32'(busy), 32'(m_active));
      check_eq("clock_pdm", 32'(clock_pdm), m_active ? 32'((m_n / m_H) % 2) : 32'd0);
      check_eq("sel_LR", 32'(sel_LR), 32'(m_sel));
      check_eq("valid", 32'(sample_valid), 32'(m_q.size() > 0));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() > 0) check_eq("data", 32'(sample_data), m_q[0]);
    end
  end

  // Background driver for mic data and consumer ready, just after negedge.
  always @(negedge clock) begin
    #1;
    case (mic_mode)
      0:       mic_in_pdm = 1'b1;
      1:       mic_in_pdm = (m_bits % 2 == 0);
      2:       mic_in_pdm = 1'($urandom_range(0, 1));
      default: mic_in_pdm = ($urandom_range(0, 63) < (((m_bits / WIN) % 8) * 8 + 4));
    endcase
    sample_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_pclk"},  32'(clock_pdm), 0);
    check_eq({tag, "_sel"},   32'(sel_LR), 0);
    check_eq({tag, "_valid"}, 32'(sample_valid), 0);
    check_eq({tag, "_data"},  32'(sample_data), 0);
    check_eq({tag, "_ovf"},   32'(overflow), 0);
  endtask

  // Release reset with a left-channel, all-ones start pending.
  task automatic run_req036();
    int t;
    half_period = 8'd15; chan_sel = 1'b0; mic_mode = 0; rdy_mode = 0; rdy_fix = 1'b1;
    enable = 1'b1;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); check_eq("rel_edge1_busy", 32'(busy), 0);
    @(negedge clock); check_eq("rel_edge2_busy", 32'(busy), 1);
    check_eq("sel_lr_left", 32'(sel_LR), 0);
    t = 0;
    while (!sample_valid && t < 11000) begin @(negedge clock); t++; end
    check_eq("first_valid_tmo", 32'(t < 11000), 1);
    check_eq("first_latency", 32'(m_n), 32'(2 * 16 * WIN * (WARMUP + 1) + 1));
    check_eq("first_data", 32'(sample_data), 64);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("stop_busy", 32'(busy), 0);
  endtask

  initial begin
    int t;
    int base;
    clock = 1'b0; reset = 1'b0; enable = 1'b0; half_period = '0; chan_sel = 1'b0;
    overflow_clr = 1'b0; mic_in_pdm = 1'b0; sample_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("rst");
    chk_on = 1'b1;

    // all-ones left channel, divider 15
    run_req036();

    // alternating bits on the right channel give exactly half scale
    half_period = 8'd1; chan_sel = 1'b1; mic_mode = 1; rdy_fix = 1'b1;
    base = m_run_wins;
    @(negedge clock); enable = 1'b1;
    t = 0;
    while (m_run_wins - base < 3 && t < 3000) begin
      @(negedge clock); t++;
      if (sample_valid) check_eq("alt_data", 32'(sample_data), 32);
    end
    check_eq("alt_tmo", 32'(t < 3000), 1);
    check_eq("sel_lr_right", 32'(sel_LR), 1);
    repeat (4) @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);

    // fill, overflow, clear collision, clear, drain
    half_period = 8'd0; chan_sel = 1'b0; mic_mode = 3; rdy_fix = 1'b0;
    base = m_run_wins;
    @(negedge clock); enable = 1'b1;
    t = 0;
    while (m_run_wins - base < 5 && t < 2000) begin @(negedge clock); t++; end
    check_eq("fill_tmo", 32'(t < 2000), 1);
    repeat (2) @(negedge clock);
    check_eq("ovf_set", 32'(overflow), 1);
    check_eq("ovf_valid", 32'(sample_valid), 1);
    t = 0;
    while (!(m_push && m_q.size() == FDEPTH) && t < 400) begin @(negedge clock); t++; end
    check_eq("clr_coll_tmo", 32'(t < 400), 1);
    overflow_clr = 1'b1;
    @(negedge clock); overflow_clr = 1'b0;
    check_eq("ovf_clr_vs_drop", 32'(overflow), 1);
    enable = 1'b0;
    @(negedge clock); overflow_clr = 1'b1;
    @(negedge clock); overflow_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 0);
    rdy_fix = 1'b1;
    repeat (6) @(negedge clock);
    check_eq("drained", 32'(sample_valid), 0);

    // full FIFO: pop and push in the same cycle keeps four entries
    mic_mode = 2; rdy_fix = 1'b0;
    @(negedge clock); enable = 1'b1;
    t = 0;
    while (!(m_push && m_q.size() == FDEPTH) && t < 3000) begin @(negedge clock); t++; end
    check_eq("pp_tmo", 32'(t < 3000), 1);
    rdy_fix = 1'b1;
    @(negedge clock); rdy_fix = 1'b0;
    check_eq("pp_ovf", 32'(overflow), 0);
    check_eq("pp_valid", 32'(sample_valid), 1);
    enable = 1'b0; rdy_fix = 1'b1;
    repeat (6) @(negedge clock);

    // stop at bit 30 of a RUN window, then restart through warmup again
    half_period = 8'd3; mic_mode = 2; rdy_mode = 1;
    @(negedge clock); enable = 1'b1;
    t = 0;
    while (!(m_bits >= WIN * WARMUP && m_bits % WIN == 30) && t < 4000) begin @(negedge clock); t++; end
    check_eq("bit30_tmo", 32'(t < 4000), 1);
    enable = 1'b0;
    @(negedge clock);
    check_eq("stop30_pclk", 32'(clock_pdm), 0);
    check_eq("stop30_busy", 32'(busy), 0);
    repeat (2) @(negedge clock);
    base = m_run_wins;
    enable = 1'b1;
    t = 0;
    while (m_run_wins - base < 2 && t < 4000) begin @(negedge clock); t++; end
    check_eq("rewarm_tmo", 32'(t < 4000), 1);
    enable = 1'b0;
    repeat (3) @(negedge clock);

    // asynchronous reset with two samples buffered
    half_period = 8'd2; chan_sel = 1'($urandom_range(0, 1)); rdy_mode = 0; rdy_fix = 1'b0;
    @(negedge clock); enable = 1'b1;
    t = 0;
    while (!(m_q.size() == 2 && !m_push && m_active) && t < 4000) begin @(negedge clock); t++; end
    check_eq("two_tmo", 32'(t < 4000), 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("async");
    repeat (2) @(negedge clock);
    run_req036();

    // randomized rounds
    for (int r = 0; r < 3; r++) begin
      half_period = 8'($urandom_range(0, 3));
      chan_sel = 1'($urandom_range(0, 1));
      mic_mode = 2; rdy_mode = 1;
      @(negedge clock); enable = 1'b1;
      for (int c = 0; c < int'($urandom_range(800, 2500)); c++) begin
        @(negedge clock);
        overflow_clr = ($urandom_range(0, 63) == 0);
      end
      overflow_clr = 1'b0; enable = 1'b0;
      repeat (3) @(negedge clock);
    end

    rdy_mode = 0; rdy_fix = 1'b1;
    repeat (8) @(negedge clock);
    check_eq("final_empty", 32'(sample_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pdm_capture_ctrl
`default_nettype wire
